// File: rtl/systolic_loader_if.sv
// Systolic loader bus: layer config, weight/bias tile strobes, and the row stream toward the array.
// No storage; pure signal bundle shared by the loader (slave) and its driver/consumer (master).
// Row stream uses valid/ready (sa_row_ov / sa_ready); tile and config strobes are single-cycle, unacknowledged.
interface systolic_loader_if #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_WIDTH = 8
);
  logic                               layer_info_iv;
  logic [3:0]                         weight_height_id;
  logic [3:0]                         weight_width_id;
  logic [3:0]                         bias_height_id;
  logic [3:0]                         bias_width_id;
  logic [2:0]                         op_id;
  logic                               is_first_layer_i;
  logic                               is_final_layer_i;
  logic                               weight_iv;
  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] weight_id;
  logic                               bias_iv;
  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] bias_id;
  logic                               sa_ready;
  logic                               sa_row_ov;
  logic [WIDTH*DATA_WIDTH-1:0]        sa_row_od;
  logic [3:0]                         sa_row_idx_od;
  logic                               sa_row_is_bias_od;
  logic [2:0]                         sa_op_od;
  logic                               sa_first_od;
  logic                               sa_final_od;
  logic                               received_SA_od;
  logic                               busy_od;
  logic                               proto_err_od;

  modport master (
    output layer_info_iv, weight_height_id, weight_width_id, bias_height_id, bias_width_id,
           op_id, is_first_layer_i, is_final_layer_i, weight_iv, weight_id, bias_iv, bias_id,
           sa_ready,
    input  sa_row_ov, sa_row_od, sa_row_idx_od, sa_row_is_bias_od, sa_op_od, sa_first_od,
           sa_final_od, received_SA_od, busy_od, proto_err_od
  );

  modport slave (
    input  layer_info_iv, weight_height_id, weight_width_id, bias_height_id, bias_width_id,
           op_id, is_first_layer_i, is_final_layer_i, weight_iv, weight_id, bias_iv, bias_id,
           sa_ready,
    output sa_row_ov, sa_row_od, sa_row_idx_od, sa_row_is_bias_od, sa_op_od, sa_first_od,
           sa_final_od, received_SA_od, busy_od, proto_err_od
  );
endinterface

// File: rtl/systolic_loader.sv
// Systolic loader: latches layer config, captures weight/bias tiles, streams them row by row to the array.
// Latency: info cycle N, tiles cycle N+1, first row valid cycle N+3; one row per cycle while sa_ready is high.
// Backpressure: a row is held stable until sa_ready; SYSTOLIC_LOADER_ZERO_PAD_EN zeroes columns >= latched width.
module systolic_loader #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  systolic_loader_if.slave bus
);

  localparam int         ROW_W = WIDTH * DATA_WIDTH;
  localparam int         IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [3:0] HMAX  = 4'(HEIGHT);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, STREAM_W, STREAM_B, DONE} state_t;

  state_t             state, state_nx;
  logic [ROW_W-1:0]   w_tile [HEIGHT];
  logic [ROW_W-1:0]   b_tile [HEIGHT];
  logic               have_w, have_b;
  logic [3:0]         w_height, b_height;
  logic [3:0]         row;
  logic [2:0]         op;
  logic               is_first, is_final;
  logic               err;
  logic               valid, is_bias, done;
  logic               info_ok, accept, w_last, b_last;
  logic [3:0]         wh_clamped, bh_clamped;
  logic [IDX_W-1:0]   row_sel;
  logic [ROW_W-1:0]   row_data;
`ifdef SYSTOLIC_LOADER_ZERO_PAD_EN
  logic [3:0]         w_width, b_width;
  logic [3:0]         cur_width;
`endif

  assign info_ok    = (state == IDLE) && bus.layer_info_iv;
  assign accept     = valid && bus.sa_ready;
  assign w_last     = (row + 4'd1) == w_height;
  assign b_last     = (row + 4'd1) == b_height;
  assign wh_clamped = (bus.weight_height_id > HMAX) ? HMAX : bus.weight_height_id;
  assign bh_clamped = (bus.bias_height_id > HMAX) ? HMAX : bus.bias_height_id;
  assign row_sel    = row[IDX_W-1:0];

  // State register; reset drops straight back to IDLE even mid-stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-state outputs; zero-height phases are skipped outright.
  always_comb begin
    state_nx = state;
    valid    = 1'b0;
    is_bias  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.layer_info_iv) state_nx = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (have_w && have_b) begin
          if (w_height != 4'd0)      state_nx = STREAM_W;
          else if (b_height != 4'd0) state_nx = STREAM_B;
          else                       state_nx = DONE;
        end
      end
      STREAM_W: begin
        valid = 1'b1;
        if (bus.sa_ready && w_last) state_nx = (b_height != 4'd0) ? STREAM_B : DONE;
      end
      STREAM_B: begin
        valid   = 1'b1;
        is_bias = 1'b1;
        if (bus.sa_ready && b_last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Row counter: advances on each accepted row, wraps to 0 at the end of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= 4'd0;
    end else if (accept) begin
      if ((is_bias && b_last) || (!is_bias && w_last)) row <= 4'd0;
      else                                               row <= row + 4'd1;
    end
  end

  // Tile capture; only WAIT_DATA accepts tiles, a repeated strobe overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < HEIGHT; h++) begin
        w_tile[h] <= '0;
        b_tile[h] <= '0;
      end
    end else if (state == WAIT_DATA) begin
      for (int h = 0; h < HEIGHT; h++) begin
        if (bus.weight_iv) w_tile[h] <= bus.weight_id[h*ROW_W +: ROW_W];
        if (bus.bias_iv)   b_tile[h] <= bus.bias_id[h*ROW_W +: ROW_W];
      end
    end
  end

  // Have-flags: set by tile strobes in WAIT_DATA, cleared when the layer completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_w <= 1'b0;
      have_b <= 1'b0;
    end else if (done || info_ok) begin
      have_w <= 1'b0;
      have_b <= 1'b0;
    end else if (state == WAIT_DATA) begin
      if (bus.weight_iv) have_w <= 1'b1;
      if (bus.bias_iv)   have_b <= 1'b1;
    end
  end

  // Layer config latch; heights are clamped to the array size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_height <= 4'd0;
      b_height <= 4'd0;
      op       <= 3'd0;
      is_first <= 1'b0;
      is_final <= 1'b0;
`ifdef SYSTOLIC_LOADER_ZERO_PAD_EN
      w_width  <= 4'd0;
      b_width  <= 4'd0;
`endif
    end else if (info_ok) begin
      w_height <= wh_clamped;
      b_height <= bh_clamped;
      op       <= bus.op_id;
      is_first <= bus.is_first_layer_i;
      is_final <= bus.is_final_layer_i;
`ifdef SYSTOLIC_LOADER_ZERO_PAD_EN
      w_width  <= bus.weight_width_id;
      b_width  <= bus.bias_width_id;
`endif
    end
  end

  // Sticky protocol error: oversize height, tile strobe in IDLE, or config strobe while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((info_ok && ((bus.weight_height_id > HMAX) || (bus.bias_height_id > HMAX))) ||
                 ((state == IDLE) && (bus.weight_iv || bus.bias_iv)) ||
                 ((state != IDLE) && bus.layer_info_iv)) begin
      err <= 1'b1;
    end
  end

`ifdef SYSTOLIC_LOADER_ZERO_PAD_EN
  assign cur_width = is_bias ? b_width : w_width;

  // Row select with columns at or beyond the latched width forced to zero.
  always_comb begin
    row_data = is_bias ? b_tile[row_sel] : w_tile[row_sel];
    for (int c = 0; c < WIDTH; c++) begin
      if (c >= int'(cur_width)) row_data[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end
`else
  assign row_data = is_bias ? b_tile[row_sel] : w_tile[row_sel];
`endif

  assign bus.sa_row_ov         = valid;
  assign bus.sa_row_od         = valid ? row_data : '0;
  assign bus.sa_row_idx_od     = row;
  assign bus.sa_row_is_bias_od = is_bias;
  assign bus.sa_op_od          = op;
  assign bus.sa_first_od       = is_first;
  assign bus.sa_final_od       = is_final;
  assign bus.received_SA_od    = done;
  assign bus.busy_od           = (state != IDLE);
  assign bus.proto_err_od      = err;

endmodule

// File: tb/tb_systolic_loader.sv
// Bench for systolic_loader: scenario tasks drive layers and compare the row stream to a queue model.
// Model builds the expected row list straight from tile contents, clamped heights and width padding.
// Honours SYSTOLIC_LOADER_ZERO_PAD_EN so the same bench serves both builds.
module tb_systolic_loader;
  localparam int W = 8, H = 8, DW = 8;
  localparam int ROW_W = W * DW;
  localparam int TILE_W = H * ROW_W;
`ifdef SYSTOLIC_LOADER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef struct packed {
    logic             bias;
    logic [3:0]       idx;
    logic [ROW_W-1:0] dat;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_loader_if #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) bus();
  systolic_loader #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int   total = 0, bad = 0;
  row_t exp_q[$], obs_q[$];
  int   stall_bad, rcv_cnt, rcv_cyc, last_acc_cyc, first_vld_cyc, w1_hold;
  logic post_busy;
  logic [TILE_W-1:0] wt, bt;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.layer_info_iv = 0; bus.weight_height_id = 0; bus.weight_width_id = 0;
    bus.bias_height_id = 0; bus.bias_width_id = 0; bus.op_id = 0;
    bus.is_first_layer_i = 0; bus.is_final_layer_i = 0;
    bus.weight_iv = 0; bus.weight_id = '0; bus.bias_iv = 0; bus.bias_id = '0; bus.sa_ready = 0;
  endtask

  task automatic rand_tile(output logic [TILE_W-1:0] t);
    for (int i = 0; i < TILE_W / 32; i++) t[i*32 +: 32] = $urandom();
  endtask

  // Expected row list: weight rows then bias rows, heights clamped to H, optional column padding.
  task automatic build_expected(input int wh, input int bh, input int ww, input int bw,
                                input logic [TILE_W-1:0] wtl, input logic [TILE_W-1:0] btl);
    row_t e;
    int   hw, hb;
    exp_q.delete();
    hw = (wh > H) ? H : wh;
    hb = (bh > H) ? H : bh;
    for (int r = 0; r < hw; r++) begin
      e.bias = 1'b0; e.idx = 4'(r); e.dat = wtl[r*ROW_W +: ROW_W];
      if (PAD_EN) for (int c = ww; c < W; c++) e.dat[c*DW +: DW] = '0;
      exp_q.push_back(e);
    end
    for (int r = 0; r < hb; r++) begin
      e.bias = 1'b1; e.idx = 4'(r); e.dat = btl[r*ROW_W +: ROW_W];
      if (PAD_EN) for (int c = bw; c < W; c++) e.dat[c*DW +: DW] = '0;
      exp_q.push_back(e);
    end
  endtask

  // Info strobe in cycle N, both tiles in N+1; returns at the start of cycle N+2.
  task automatic send_layer(input logic [3:0] wh, input logic [3:0] bh, input logic [3:0] ww,
                            input logic [3:0] bw, input logic [2:0] op, input logic f, input logic l,
                            input logic [TILE_W-1:0] wtl, input logic [TILE_W-1:0] btl);
    bus.weight_height_id = wh; bus.bias_height_id = bh;
    bus.weight_width_id = ww; bus.bias_width_id = bw;
    bus.op_id = op; bus.is_first_layer_i = f; bus.is_final_layer_i = l;
    bus.layer_info_iv = 1; cyc(); bus.layer_info_iv = 0;
    bus.weight_id = wtl; bus.bias_id = btl; bus.weight_iv = 1; bus.bias_iv = 1;
    cyc();
    bus.weight_iv = 0; bus.bias_iv = 0;
  endtask

  // Consume the row stream. mode 0: ready high; 1: random ready; 2: stall weight row 1 for two cycles.
  task automatic collect(input int mode, input int max_cyc);
    row_t cur, prev;
    logic held, r;
    int   stalls;
    obs_q.delete();
    stall_bad = 0; rcv_cnt = 0; rcv_cyc = -1; last_acc_cyc = -1; first_vld_cyc = -1;
    w1_hold = 0; held = 0; stalls = 0; post_busy = 1'bx; prev = '0;
    for (int k = 0; k < max_cyc; k++) begin
      cur.bias = bus.sa_row_is_bias_od; cur.idx = bus.sa_row_idx_od; cur.dat = bus.sa_row_od;
      if (bus.sa_row_ov) begin
        if (first_vld_cyc < 0) first_vld_cyc = k;
        if (held && cur !== prev) stall_bad++;
        if (!cur.bias && cur.idx == 4'd1) w1_hold++;
      end
      if (bus.received_SA_od) begin
        rcv_cnt++;
        if (rcv_cyc < 0) rcv_cyc = k;
      end
      if (rcv_cyc >= 0 && k == rcv_cyc + 1) post_busy = bus.busy_od;
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: begin
          r = !(bus.sa_row_ov && !cur.bias && cur.idx == 4'd1 && stalls < 2);
          if (!r) stalls++;
        end
      endcase
      bus.sa_ready = r;
      if (bus.sa_row_ov && r) begin
        obs_q.push_back(cur);
        last_acc_cyc = k;
      end
      held = bus.sa_row_ov && !r;
      prev = cur;
      if (rcv_cyc >= 0 && k == rcv_cyc + 2) break;
      cyc();
    end
    bus.sa_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    total++;
    if ({bus.sa_row_ov, bus.sa_row_od, bus.sa_row_idx_od, bus.sa_row_is_bias_od, bus.sa_op_od,
         bus.sa_first_od, bus.sa_final_od, bus.received_SA_od} !== '0) begin
      bad++; $display("FAIL reset_outputs ov=%b od=%h idx=%0d op=%b want all zero",
                      bus.sa_row_ov, bus.sa_row_od, bus.sa_row_idx_od, bus.sa_op_od);
    end
    total++;
    if (bus.busy_od !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_od); end
    total++;
    if (bus.proto_err_od !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.proto_err_od); end
    rst = 0;
    cyc();
  endtask

  task automatic test_basic();
    rand_tile(wt); rand_tile(bt);
    build_expected(3, 1, 8, 8, wt, bt);
    send_layer(4'd3, 4'd1, 4'd8, 4'd8, 3'b101, 1'b1, 1'b0, wt, bt);
    collect(0, 100);
    total++;
    if (rcv_cyc < 0) begin bad++; $display("FAIL basic_timeout got=no_pulse want=pulse"); end
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL basic_rows got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_row%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (first_vld_cyc !== 1) begin bad++; $display("FAIL basic_first_valid got=%0d want=1", first_vld_cyc); end
    total++;
    if (last_acc_cyc !== 4) begin bad++; $display("FAIL basic_last_accept got=%0d want=4", last_acc_cyc); end
    total++;
    if (rcv_cyc !== 5 || rcv_cnt !== 1) begin
      bad++; $display("FAIL basic_received cyc=%0d cnt=%0d want cyc=5 cnt=1", rcv_cyc, rcv_cnt);
    end
    total++;
    if (post_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", post_busy); end
    total++;
    if ({bus.sa_op_od, bus.sa_first_od, bus.sa_final_od} !== 5'b101_1_0) begin
      bad++; $display("FAIL basic_config got=%b want=10110", {bus.sa_op_od, bus.sa_first_od, bus.sa_final_od});
    end
    total++;
    if (bus.proto_err_od !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.proto_err_od); end
  endtask

  task automatic test_stall();
    rand_tile(wt); rand_tile(bt);
    build_expected(3, 1, 8, 8, wt, bt);
    send_layer(4'd3, 4'd1, 4'd8, 4'd8, 3'b010, 1'b0, 1'b1, wt, bt);
    collect(2, 100);
    total++;
    if (w1_hold !== 3) begin bad++; $display("FAIL stall_hold got=%0d want=3", w1_hold); end
    total++;
    if (stall_bad !== 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stall_bad); end
    total++;
    if (obs_q != exp_q) begin
      bad++; $display("FAIL stall_rows got_n=%0d want_n=%0d", obs_q.size(), exp_q.size());
    end
    total++;
    if (rcv_cyc < 0 || rcv_cyc !== last_acc_cyc + 1) begin
      bad++; $display("FAIL stall_received got=%0d want=%0d", rcv_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_zero_height();
    rand_tile(wt); rand_tile(bt);
    build_expected(0, 2, 8, 8, wt, bt);
    send_layer(4'd0, 4'd2, 4'd8, 4'd8, 3'b001, 1'b0, 1'b0, wt, bt);
    collect(0, 100);
    total++;
    if (obs_q != exp_q) begin
      bad++; $display("FAIL zero_rows got_n=%0d want_n=%0d", obs_q.size(), exp_q.size());
    end
    total++;
    if (first_vld_cyc !== 1 || rcv_cyc !== 3 || rcv_cnt !== 1) begin
      bad++; $display("FAIL zero_timing first=%0d rcv=%0d cnt=%0d want 1 3 1", first_vld_cyc, rcv_cyc, rcv_cnt);
    end
  endtask

  task automatic test_proto_err();
    bus.weight_iv = 1; cyc(); bus.weight_iv = 0;
    total++;
    if (bus.proto_err_od !== 1'b1 || bus.busy_od !== 1'b0) begin
      bad++; $display("FAIL err_idle_strobe err=%b busy=%b want err=1 busy=0", bus.proto_err_od, bus.busy_od);
    end
    rand_tile(wt); rand_tile(bt);
    build_expected(9, 0, 8, 8, wt, bt);
    send_layer(4'd9, 4'd0, 4'd8, 4'd8, 3'b100, 1'b0, 1'b0, wt, bt);
    collect(0, 100);
    total++;
    if (obs_q.size() !== 8 || obs_q != exp_q) begin
      bad++; $display("FAIL err_clamp_rows got_n=%0d want_n=8", obs_q.size());
    end
    total++;
    if (bus.proto_err_od !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.proto_err_od); end
    rst = 1; cyc(); rst = 0; cyc();
    total++;
    if (bus.proto_err_od !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", bus.proto_err_od); end
    // Config strobe while in WAIT_DATA must be ignored but flagged.
    rand_tile(wt); rand_tile(bt);
    build_expected(1, 0, 8, 8, wt, bt);
    bus.weight_height_id = 4'd1; bus.bias_height_id = 4'd0; bus.op_id = 3'b011;
    bus.layer_info_iv = 1; cyc();
    bus.op_id = 3'b111; bus.weight_height_id = 4'd5;
    bus.weight_id = wt; bus.bias_id = bt; bus.weight_iv = 1; bus.bias_iv = 1;
    cyc();
    bus.layer_info_iv = 0; bus.weight_iv = 0; bus.bias_iv = 0;
    total++;
    if (bus.proto_err_od !== 1'b1) begin bad++; $display("FAIL err_info_busy got=%b want=1", bus.proto_err_od); end
    collect(0, 100);
    total++;
    if (obs_q != exp_q || bus.sa_op_od !== 3'b011) begin
      bad++; $display("FAIL err_info_ignored rows=%0d op=%b want rows=1 op=011", obs_q.size(), bus.sa_op_od);
    end
  endtask

  task automatic test_reset_mid();
    rand_tile(wt); rand_tile(bt);
    send_layer(4'd3, 4'd1, 4'd8, 4'd8, 3'b110, 1'b1, 1'b1, wt, bt);
    bus.sa_ready = 1;
    cyc(); cyc();
    total++;
    if (bus.sa_row_ov !== 1'b1 || bus.sa_row_idx_od !== 4'd1) begin
      bad++; $display("FAIL midrst_setup ov=%b idx=%0d want ov=1 idx=1", bus.sa_row_ov, bus.sa_row_idx_od);
    end
    rst = 1;
    #1;
    total++;
    if (bus.sa_row_ov !== 1'b0 || bus.busy_od !== 1'b0 || bus.sa_op_od !== 3'b000) begin
      bad++; $display("FAIL midrst_immediate ov=%b busy=%b op=%b want 0 0 000", bus.sa_row_ov, bus.busy_od, bus.sa_op_od);
    end
    bus.sa_ready = 0;
    cyc(); rst = 0; cyc();
    rand_tile(wt); rand_tile(bt);
    build_expected(2, 1, 8, 8, wt, bt);
    send_layer(4'd2, 4'd1, 4'd8, 4'd8, 3'b000, 1'b0, 1'b0, wt, bt);
    collect(0, 100);
    total++;
    if (obs_q != exp_q) begin
      bad++; $display("FAIL midrst_restart got_n=%0d want_n=%0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_pad();
    logic [ROW_W-1:0] want;
    want = PAD_EN ? 64'h0000_00FF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    wt = '1; bt = '1;
    send_layer(4'd1, 4'd1, 4'd5, 4'd5, 3'b000, 1'b0, 1'b0, wt, bt);
    collect(0, 100);
    total++;
    if (obs_q.size() !== 2) begin
      bad++; $display("FAIL pad_rows got=%0d want=2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0].dat !== want) begin bad++; $display("FAIL pad_weight got=%h want=%h", obs_q[0].dat, want); end
      total++;
      if (obs_q[1].dat !== want) begin bad++; $display("FAIL pad_bias got=%h want=%h", obs_q[1].dat, want); end
    end
  endtask

  task automatic test_random();
    int         wh, bh, ww, bw;
    logic [2:0] op;
    logic       exp_err;
    rst = 1; cyc(); rst = 0; cyc();
    exp_err = 0;
    for (int n = 0; n < 10; n++) begin
      wh = $urandom_range(0, 10); bh = $urandom_range(0, 10);
      ww = $urandom_range(0, 9);  bw = $urandom_range(0, 9);
      op = 3'($urandom_range(0, 7));
      rand_tile(wt); rand_tile(bt);
      build_expected(wh, bh, ww, bw, wt, bt);
      if (wh > H || bh > H) exp_err = 1;
      send_layer(4'(wh), 4'(bh), 4'(ww), 4'(bw), op, 1'b0, 1'b1, wt, bt);
      collect(1, 300);
      total++;
      if (rcv_cyc < 0 || obs_q != exp_q || stall_bad !== 0) begin
        bad++; $display("FAIL rand%0d_stream wh=%0d bh=%0d got_n=%0d want_n=%0d stall_bad=%0d rcv=%0d",
                        n, wh, bh, obs_q.size(), exp_q.size(), stall_bad, rcv_cyc);
      end
      total++;
      if (bus.sa_op_od !== op || bus.proto_err_od !== exp_err) begin
        bad++; $display("FAIL rand%0d_flags op=%b err=%b want op=%b err=%b", n, bus.sa_op_od, bus.proto_err_od, op, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_height();
    test_proto_err();
    test_reset_mid();
    test_pad();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_loader.md
SYSTOLIC_LOADER -- requirements
Module: systolic_loader

Interface
REQ-001 Parameter WIDTH, default 8: systolic array columns.
REQ-002 Parameter HEIGHT, default 8: systolic array rows.
REQ-003 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 layer_info_iv  input  1  layer-info strobe from register file.
REQ-007 weight_height_id, weight_width_id, bias_height_id, bias_width_id  input  4 each  layer dimensions.
REQ-008 op_id  input  3  {reLU_sel, op_sel, flatten}.
REQ-009 is_first_layer_i, is_final_layer_i  input  1 each  layer position flags.
REQ-010 weight_iv  input  1; weight_id  input  HEIGHT*WIDTH*DATA_WIDTH  weight tile.
REQ-011 bias_iv  input  1; bias_id  input  HEIGHT*WIDTH*DATA_WIDTH  bias tile.
REQ-012 sa_ready  input  1  systolic array accepts a row this cycle.
REQ-013 sa_row_ov  output  1  row valid.
REQ-014 sa_row_od  output  WIDTH*DATA_WIDTH  row data.
REQ-015 sa_row_idx_od  output  4  row index within tile.
REQ-016 sa_row_is_bias_od  output  1  0 = weight row, 1 = bias row.
REQ-017 sa_op_od  output  3; sa_first_od, sa_final_od  output  1 each  latched layer config.
REQ-018 received_SA_od  output  1  one-cycle pulse: layer fully delivered.
REQ-019 busy_od  output  1  high in every state except IDLE.
REQ-020 proto_err_od  output  1  sticky protocol-error flag.

Function
REQ-021 States IDLE, WAIT_DATA, STREAM_W, STREAM_B, DONE; one-hot or binary at implementer's choice.
REQ-022 IDLE: layer_info_iv=1 latches all dimensions, op and flags; next state WAIT_DATA.
REQ-023 WAIT_DATA: weight_iv / bias_iv each capture their tile and set a have-flag; same-cycle strobes both captured.
REQ-024 WAIT_DATA exits to STREAM_W on the cycle after both have-flags are set; a repeated strobe overwrites the tile, no error.
REQ-025 STREAM_W: sa_row_ov=1, row r of weight tile, idx=r, is_bias=0; r advances only on sa_ready&sa_row_ov; row data held stable while sa_ready=0.
REQ-026 After row weight_height-1 is accepted -> STREAM_B with r=0; STREAM_B identical on bias tile, bound bias_height.
REQ-027 After last bias row accepted -> DONE; DONE drives received_SA_od=1 for exactly one cycle, then IDLE; have-flags cleared.
REQ-028 Height 0: corresponding stream phase skipped with zero cycles of sa_row_ov.
REQ-029 Height > HEIGHT: clamped to HEIGHT and proto_err_od set.
REQ-030 weight_iv/bias_iv in IDLE, or layer_info_iv outside IDLE: ignored, proto_err_od set.
REQ-031 Best-case latency: info cycle N, both tiles cycle N+1, first row valid cycle N+3; one row per cycle with sa_ready held high.
REQ-032 sa_op_od, sa_first_od, sa_final_od hold latched values until next accepted layer_info_iv.

Reset
REQ-033 rst=1 forces IDLE immediately, including mid-stream; all outputs 0, tiles and config registers 0, proto_err_od cleared.
REQ-034 Only rst clears proto_err_od.

Configuration
REQ-035 Macro SYSTOLIC_LOADER_ZERO_PAD_EN defined: columns >= latched width of sa_row_od driven 0.
REQ-036 Macro SYSTOLIC_LOADER_ZERO_PAD_EN undefined: all WIDTH columns passed unmodified; no width masking logic.

Verification
REQ-037 Info (wh=3,bh=1), weight+bias same cycle, sa_ready=1 -> rows w0,w1,w2,b0 on consecutive cycles, received_SA_od pulse one cycle after b0.
REQ-038 sa_ready low 2 cycles during w1 -> w1 held 3 cycles, stable data, no row skipped.
REQ-039 wh=0, bh=2 -> no weight rows; b0,b1 then received_SA_od pulse.
REQ-040 weight_iv in IDLE, then wh=9 -> proto_err_od=1, stays 1 until rst, 8 weight rows sent.
REQ-041 rst asserted during STREAM_W row 1 -> sa_row_ov=0, busy_od=0 same cycle; next layer streams from row 0.
REQ-042 With SYSTOLIC_LOADER_ZERO_PAD_EN, width=5, all-0xFF tile -> columns 5..7 read 0x00; without macro -> 0xFF.
